shift_sequencer: RTL and testbench

Iterative multi-cycle shift controller for the EX stage of the pipelined RISC-V core. It decodes SLL/SRL/SRA and SLLI/SRLI/SRAI from the opcode and func3, and extracts the 5-bit shift amount. It then performs the shift over several cycles, at most STEP bit positions per cycle. While the shift is in progress it stalls the pipeline, and it presents the result with a one-cycle done pulse.

---
 rtl/shift_sequencer.sv | 112 +++++++++++
 tb/tb_shift_sequencer.sv | 225 ++++++++++++++++++++++
 2 files changed

// File: rtl/shift_sequencer.sv
// Multi-cycle SLL/SRL/SRA(I) unit for the EX stage: shifts at most STEP bits
// per cycle, stalls the pipeline while working and pulses done with the result.
module shift_sequencer #(
    parameter int STEP = 4
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        start,
    input  logic        flush,
    input  logic [6:0]  op,
    input  logic [2:0]  func3,
    input  logic        func7_5,
    input  logic [31:0] rs1_data,
    input  logic [31:0] rs2_data,
    input  logic [31:0] imm,
    output logic        stall,
    output logic        busy,
    output logic        done,
    output logic [31:0] result
);
    localparam logic [6:0] OP_R   = 7'b0110011;
    localparam logic [6:0] OP_I   = 7'b0010011;
    localparam logic [4:0] STEP_W = 5'(STEP);

    typedef enum logic [1:0] {IDLE, SHIFT, DONE} state_t;

    typedef struct packed {
        logic left;
        logic arith;
    } kind_t;

    state_t      state_q, state_d;
    logic [31:0] acc_q, acc_shifted, result_q;
    logic [4:0]  rem_q, step, shamt;
    kind_t       kind_q, kind_dec;
    logic        is_r, is_i, is_shift, accept;

    // Only the shift-amount and SRAI-select bits of the operands are used.
    logic unused_ok;
    assign unused_ok = ^{rs2_data[31:5], imm[31:11], imm[9:5]};

    // Decode
    always_comb begin
        is_r           = (op == OP_R);
        is_i           = (op == OP_I);
        is_shift       = (is_r || is_i) && (func3 == 3'b001 || func3 == 3'b101);
        shamt          = is_r ? rs2_data[4:0] : imm[4:0];
        kind_dec.left  = (func3 == 3'b001);
        kind_dec.arith = !kind_dec.left && (is_r ? func7_5 : imm[10]);
        accept         = (state_q == IDLE) && start && is_shift && !flush;
    end

    // One step of the iterative shift
    always_comb begin
        step = (rem_q < STEP_W) ? rem_q : STEP_W;
        if (kind_q.left)
            acc_shifted = acc_q << step;
        else if (kind_q.arith)
            acc_shifted = 32'($signed(acc_q) >>> step);
        else
            acc_shifted = acc_q >> step;
    end

    always_ff @(posedge clk) begin
        if (!rst_n)
            state_q <= IDLE;
        else
            state_q <= state_d;
    end

    always_comb begin
        state_d = state_q;
        if (flush) begin
            state_d = IDLE;
        end else begin
            case (state_q)
                IDLE:    if (start && is_shift) state_d = (shamt == 5'd0) ? DONE : SHIFT;
                SHIFT:   if (rem_q <= STEP_W) state_d = DONE;
                DONE:    state_d = IDLE;
                default: state_d = IDLE;
            endcase
        end
    end

    always_comb begin
        stall  = rst_n && (accept || state_q == SHIFT);
        busy   = rst_n && (state_q != IDLE);
        done   = rst_n && (state_q == DONE) && !flush;
        // acc already holds the final value in DONE; result_q captures it as the cycle ends.
        result = done ? acc_q : result_q;
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            acc_q    <= '0;
            rem_q    <= '0;
            kind_q   <= '0;
            result_q <= '0;
        end else begin
            if (accept) begin
                acc_q  <= rs1_data;
                rem_q  <= shamt;
                kind_q <= kind_dec;
            end else if (state_q == SHIFT && !flush) begin
                acc_q <= acc_shifted;
                rem_q <= rem_q - step;
            end
            if (done)
                result_q <= acc_q;
        end
    end
endmodule

// File: tb/tb_shift_sequencer.sv
// Bench for shift_sequencer: directed vector table, multi-cycle corner sequences
// (flush, reset, non-shift ops) and random shifts against an arithmetic model.
module tb_shift_sequencer;
    localparam int STEP = 4;
    localparam logic [6:0] OP_R = 7'b0110011;
    localparam logic [6:0] OP_I = 7'b0010011;

    logic        clk = 1'b0;
    logic        rst_n, start, flush, func7_5;
    logic [6:0]  op;
    logic [2:0]  func3;
    logic [31:0] rs1_data, rs2_data, imm, result;
    logic        stall, busy, done;

    int checks = 0;
    int errors = 0;
    logic [31:0] prev_result = 32'h0;

    shift_sequencer #(.STEP(STEP)) dut (
        .clk(clk), .rst_n(rst_n), .start(start), .flush(flush), .op(op),
        .func3(func3), .func7_5(func7_5), .rs1_data(rs1_data),
        .rs2_data(rs2_data), .imm(imm), .stall(stall), .busy(busy),
        .done(done), .result(result)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [6:0]  op;
        logic [2:0]  f3;
        logic        f7;
        logic [31:0] rs1;
        logic [31:0] rs2;
        logic [31:0] imm;
        logic [31:0] exp_res;
        int          k;
    } vec_t;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic next_cycle();
        @(posedge clk);
        #1;
    endtask

    task automatic set_op(input logic [6:0] o, input logic [2:0] f3, input logic f7,
                          input logic [31:0] a, input logic [31:0] b, input logic [31:0] im);
        op = o; func3 = f3; func7_5 = f7; rs1_data = a; rs2_data = b; imm = im;
    endtask

    // Higher-level reference: shift by the whole amount at once, latency from ceil division.
    task automatic model(input logic [6:0] o, input logic [2:0] f3, input logic f7,
                         input logic [31:0] a, input logic [31:0] b, input logic [31:0] im,
                         output logic [31:0] res, output int k);
        int sh;
        logic arith;
        sh    = (o == OP_R) ? int'(b[4:0]) : int'(im[4:0]);
        arith = (o == OP_R) ? f7 : im[10];
        if (f3 == 3'b001)  res = a << sh;
        else if (arith)    res = 32'($signed(a) >>> sh);
        else               res = a >> sh;
        k = (sh + STEP - 1) / STEP;
    endtask

    // Accept in the first cycle, expect stall for k+1 cycles then a done pulse.
    // start stays high through DONE; the next call's first cycle checks it was not re-accepted.
    task automatic run_op(input logic [6:0] o, input logic [2:0] f3, input logic f7,
                          input logic [31:0] a, input logic [31:0] b, input logic [31:0] im,
                          input logic [31:0] exp_res, input int k);
        next_cycle();
        start = 1'b1; flush = 1'b0;
        set_op(o, f3, f7, a, b, im);
        for (int c = 0; c <= k + 1; c++) begin
            if (c > 0) next_cycle();
            @(negedge clk);
            chk($sformatf("stall c%0d", c), 32'(stall), 32'(c <= k));
            chk($sformatf("busy c%0d", c),  32'(busy),  32'(c != 0));
            chk($sformatf("done c%0d", c),  32'(done),  32'(c == k + 1));
            chk($sformatf("result c%0d", c), result, (c == k + 1) ? exp_res : prev_result);
        end
        prev_result = exp_res;
    endtask

    task automatic check_idle(input string tag);
        @(negedge clk);
        chk({tag, " stall"}, 32'(stall), 32'd0);
        chk({tag, " busy"},  32'(busy),  32'd0);
        chk({tag, " done"},  32'(done),  32'd0);
        chk({tag, " result"}, result, prev_result);
    endtask

    vec_t vecs[11];

    initial begin
        logic [31:0] r_exp;
        int          r_k;
        logic [6:0]  r_op;
        logic [2:0]  r_f3;

        vecs[0]  = '{OP_R, 3'b001, 1'b0, 32'h00000001, 32'h0000001F, 32'h0,        32'h80000000, 8};
        vecs[1]  = '{OP_I, 3'b101, 1'b0, 32'h80000000, 32'h0,        32'h00000404, 32'hF8000000, 1};
        vecs[2]  = '{OP_I, 3'b101, 1'b0, 32'h80000000, 32'h0,        32'h00000004, 32'h08000000, 1};
        vecs[3]  = '{OP_R, 3'b101, 1'b0, 32'hFFFFFFFF, 32'h00000025, 32'h0,        32'h07FFFFFF, 2};
        vecs[4]  = '{OP_R, 3'b101, 1'b0, 32'h12345678, 32'h00000020, 32'h0,        32'h12345678, 0};
        vecs[5]  = '{OP_R, 3'b101, 1'b1, 32'h80000000, 32'h00000004, 32'h0,        32'hF8000000, 1};
        vecs[6]  = '{OP_I, 3'b001, 1'b0, 32'h40000001, 32'h0,        32'h00000001, 32'h80000002, 1};
        vecs[7]  = '{OP_I, 3'b101, 1'b0, 32'h80000000, 32'h0,        32'h0000041F, 32'hFFFFFFFF, 8};
        vecs[8]  = '{OP_R, 3'b101, 1'b1, 32'h7FFFFFFF, 32'h00000003, 32'h0,        32'h0FFFFFFF, 1};
        vecs[9]  = '{OP_I, 3'b101, 1'b1, 32'h80000000, 32'h0,        32'h00000008, 32'h00800000, 2};
        vecs[10] = '{OP_R, 3'b101, 1'b0, 32'h80000000, 32'h00000008, 32'h00000400, 32'h00800000, 2};

        // Reset with a valid shift presented: nothing may respond
        rst_n = 1'b0; start = 1'b1; flush = 1'b0;
        set_op(OP_R, 3'b001, 1'b0, 32'h1, 32'h1F, 32'h0);
        repeat (2) @(posedge clk);
        for (int i = 0; i < 2; i++) check_idle($sformatf("reset%0d", i));
        next_cycle();
        rst_n = 1'b1; start = 1'b0;
        check_idle("post_reset");

        foreach (vecs[i])
            run_op(vecs[i].op, vecs[i].f3, vecs[i].f7, vecs[i].rs1, vecs[i].rs2,
                   vecs[i].imm, vecs[i].exp_res, vecs[i].k);

        // Non-shift instructions held valid
        next_cycle();
        start = 1'b1;
        set_op(OP_R, 3'b000, 1'b0, 32'h5, 32'h3, 32'h0);
        for (int i = 0; i < 3; i++) begin
            check_idle($sformatf("add%0d", i));
            next_cycle();
        end
        set_op(7'b1100011, 3'b001, 1'b0, 32'h5, 32'h3, 32'h0);
        check_idle("bne");

        // Flush at T+3 during a 31-bit shift
        next_cycle();
        start = 1'b1;
        set_op(OP_R, 3'b001, 1'b0, 32'h1, 32'h1F, 32'h0);
        @(negedge clk);
        chk("flush accept stall", 32'(stall), 32'd1);
        for (int c = 1; c <= 2; c++) begin
            next_cycle();
            @(negedge clk);
            chk($sformatf("flush busy c%0d", c), 32'(busy), 32'd1);
        end
        next_cycle();
        flush = 1'b1;
        @(negedge clk);
        chk("flush cycle stall", 32'(stall), 32'd1);
        chk("flush cycle done", 32'(done), 32'd0);
        next_cycle();
        flush = 1'b0; start = 1'b0;
        for (int i = 0; i < 10; i++) begin
            check_idle($sformatf("after_flush%0d", i));
            next_cycle();
        end
        run_op(OP_I, 3'b001, 1'b0, 32'h00000003, 32'h0, 32'h00000001, 32'h00000006, 1);

        // Flush coinciding with the accept cycle
        next_cycle();
        start = 1'b1; flush = 1'b1;
        set_op(OP_R, 3'b001, 1'b0, 32'h1, 32'h4, 32'h0);
        @(negedge clk);
        chk("flush_idle stall", 32'(stall), 32'd0);
        next_cycle();
        start = 1'b0; flush = 1'b0;
        check_idle("flush_idle next");

        // Flush during DONE suppresses the pulse and keeps the old result
        next_cycle();
        start = 1'b1;
        set_op(OP_R, 3'b101, 1'b0, 32'hDEADBEEF, 32'h0, 32'h0);
        @(negedge clk);
        chk("flush_done accept stall", 32'(stall), 32'd1);
        next_cycle();
        flush = 1'b1;
        @(negedge clk);
        chk("flush_done busy", 32'(busy), 32'd1);
        chk("flush_done done", 32'(done), 32'd0);
        chk("flush_done result", result, prev_result);
        next_cycle();
        flush = 1'b0; start = 1'b0;
        check_idle("flush_done next");

        // Reset at T+2 mid-shift
        next_cycle();
        start = 1'b1;
        set_op(OP_R, 3'b001, 1'b0, 32'h1, 32'h1F, 32'h0);
        next_cycle();
        next_cycle();
        rst_n = 1'b0;
        @(negedge clk);
        chk("rst_mid stall", 32'(stall), 32'd0);
        chk("rst_mid busy", 32'(busy), 32'd0);
        chk("rst_mid done", 32'(done), 32'd0);
        next_cycle();
        rst_n = 1'b1; start = 1'b0;
        prev_result = 32'h0;
        check_idle("rst_after");
        run_op(OP_R, 3'b101, 1'b1, 32'h80000010, 32'h00000004, 32'h0, 32'hF8000001, 1);

        // Random back-to-back shifts against the model
        for (int i = 0; i < 40; i++) begin
            r_op = $urandom_range(0, 1) ? OP_R : OP_I;
            r_f3 = $urandom_range(0, 1) ? 3'b001 : 3'b101;
            set_op(r_op, r_f3, 1'($urandom), $urandom, $urandom, $urandom);
            model(op, func3, func7_5, rs1_data, rs2_data, imm, r_exp, r_k);
            run_op(op, func3, func7_5, rs1_data, rs2_data, imm, r_exp, r_k);
        end

        next_cycle();
        start = 1'b0;
        check_idle("final");

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
